// File: rtl/weight_tile_router.sv
// Weight-SRAM scanner that routes words into per-slot lane FIFOs by address range.
// Optional WEIGHT_ROUTER_STATS_EN adds saturating push/drop counters.
module weight_tile_router #(
   parameter int COUNT      = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
)(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_reg_clear,
   input  logic                          i_addr_write_en,
   input  logic [$clog2(COUNT)-1:0]      i_id,
   input  logic [ADDR_WIDTH-1:0]         i_start_addr,
   input  logic [ADDR_WIDTH-1:0]         i_end_addr,
   input  logic                          i_route_en,
   input  logic [ADDR_WIDTH-1:0]         i_read_start,
   input  logic [ADDR_WIDTH-1:0]         i_read_end,
   output logic                          o_sram_re,
   output logic [ADDR_WIDTH-1:0]         o_sram_addr,
   input  logic [DATA_WIDTH-1:0]         i_sram_data,
   input  logic                          i_pop_en,
   output logic [COUNT*DATA_WIDTH-1:0]   o_data,
   output logic [COUNT-1:0]              o_valid,
   output logic                          o_fifo_pop_ready,
   output logic                          o_fifo_empty,
   output logic                          o_overflow
`ifdef WEIGHT_ROUTER_STATS_EN
   ,
   output logic [15:0]                   o_push_count,
   output logic [15:0]                   o_drop_count
`endif
);

   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, READY, POP} state_t;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
   localparam logic [PW-1:0] P_ONE = PW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

   state_t state, state_n;

   logic [ADDR_WIDTH-1:0] cur, rend;
   logic                  rd_vld;
   logic [ADDR_WIDTH-1:0] rd_addr;

   logic [ADDR_WIDTH-1:0] slot_start [COUNT];
   logic [ADDR_WIDTH-1:0] slot_end   [COUNT];

   logic [DATA_WIDTH-1:0] mem  [COUNT][FIFO_DEPTH];
   logic [PW-1:0]         wptr [COUNT];
   logic [PW-1:0]         rptr [COUNT];
   logic [CW-1:0]         cnt  [COUNT];

   logic [COUNT-1:0] hit, full, nonempty, last, push, pop, ovf_hit;
   logic pop_phase, all_empty, all_last;

   always_comb begin
      pop_phase = (state == READY) || (state == POP);
      hit       = '0;
      full      = '0;
      nonempty  = '0;
      last      = '0;
      push      = '0;
      pop       = '0;
      ovf_hit   = '0;
      for (int k = 0; k < COUNT; k++) begin
         hit[k]      = rd_vld && (slot_start[k] <= rd_addr)
                       && (rd_addr < slot_end[k]);
         full[k]     = (cnt[k] == C_FULL);
         nonempty[k] = (cnt[k] != '0);
         last[k]     = (cnt[k] <= C_ONE);
         push[k]     = hit[k] && !full[k];
         ovf_hit[k]  = hit[k] && full[k];
         pop[k]      = pop_phase && i_pop_en && nonempty[k];
      end
      all_empty = ~|nonempty;
      all_last  = &last;
   end

   always_comb begin
      o_sram_re        = (state == SCAN);
      o_sram_addr      = o_sram_re ? cur : '0;
      o_fifo_pop_ready = pop_phase;
      o_fifo_empty     = all_empty && !rd_vld;
   end

   // DRAIN lasts one cycle: the final in-flight word is pushed on its exit edge
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (i_route_en)
               state_n = (i_read_start < i_read_end) ? SCAN : DRAIN;
         end
         SCAN: begin
            if (cur + A_ONE == rend)
               state_n = DRAIN;
         end
         DRAIN: state_n = READY;
         READY: begin
            if (i_pop_en)
               state_n = all_last ? IDLE : POP;
         end
         POP: begin
            if ((i_pop_en && all_last) || all_empty)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         cur        <= '0;
         rend       <= '0;
         rd_vld     <= 1'b0;
         rd_addr    <= '0;
         o_data     <= '0;
         o_valid    <= '0;
         o_overflow <= 1'b0;
         for (int k = 0; k < COUNT; k++) begin
            slot_start[k] <= '0;
            slot_end[k]   <= '0;
            wptr[k]       <= '0;
            rptr[k]       <= '0;
            cnt[k]        <= '0;
         end
      end else if (i_reg_clear) begin
         state      <= IDLE;
         cur        <= '0;
         rend       <= '0;
         rd_vld     <= 1'b0;
         rd_addr    <= '0;
         o_data     <= '0;
         o_valid    <= '0;
         o_overflow <= 1'b0;
         for (int k = 0; k < COUNT; k++) begin
            slot_start[k] <= '0;
            slot_end[k]   <= '0;
            wptr[k]       <= '0;
            rptr[k]       <= '0;
            cnt[k]        <= '0;
         end
      end else begin
         state   <= state_n;
         rd_vld  <= o_sram_re;
         rd_addr <= o_sram_addr;
         if (state == IDLE && i_route_en) begin
            cur  <= i_read_start;
            rend <= i_read_end;
         end else if (state == SCAN) begin
            cur <= cur + A_ONE;
         end
         if (i_addr_write_en && (int'(i_id) < COUNT)) begin
            slot_start[i_id] <= i_start_addr;
            slot_end[i_id]   <= i_end_addr;
         end
         o_valid <= pop;
         for (int k = 0; k < COUNT; k++) begin
            if (push[k])
               wptr[k] <= wptr[k] + P_ONE;
            if (pop[k]) begin
               rptr[k] <= rptr[k] + P_ONE;
               o_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem[k][rptr[k]];
            end
            if (push[k] && !pop[k])
               cnt[k] <= cnt[k] + C_ONE;
            else if (pop[k] && !push[k])
               cnt[k] <= cnt[k] - C_ONE;
         end
         if (|ovf_hit)
            o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < COUNT; k++) begin
         if (push[k] && !i_reg_clear)
            mem[k][wptr[k]] <= i_sram_data;
      end
   end

`ifdef WEIGHT_ROUTER_STATS_EN
   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [15:0] push_inc, drop_inc;

   // a word hitting no slot is one drop; each full lane it hits is another
   always_comb begin
      push_inc = 16'($countones(push));
      drop_inc = 16'($countones(ovf_hit))
                 + ((rd_vld && (hit == '0)) ? 16'd1 : 16'd0);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_push_count <= '0;
         o_drop_count <= '0;
      end else if (i_reg_clear) begin
         o_push_count <= '0;
         o_drop_count <= '0;
      end else begin
         o_push_count <= sat_add(o_push_count, push_inc);
         o_drop_count <= sat_add(o_drop_count, drop_inc);
      end
   end
`endif

endmodule

// File: tb/tb_weight_tile_router.sv
// Directed plus randomized bench for weight_tile_router against a queue model.
module tb_weight_tile_router;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_reg_clear = 1'b0;
   logic        i_addr_write_en = 1'b0;
   logic [1:0]  i_id = '0;
   logic [7:0]  i_start_addr = '0;
   logic [7:0]  i_end_addr = '0;
   logic        i_route_en = 1'b0;
   logic [7:0]  i_read_start = '0;
   logic [7:0]  i_read_end = '0;
   logic        o_sram_re;
   logic [7:0]  o_sram_addr;
   logic [7:0]  i_sram_data = '0;
   logic        i_pop_en = 1'b0;
   logic [31:0] o_data;
   logic [3:0]  o_valid;
   logic        o_fifo_pop_ready;
   logic        o_fifo_empty;
   logic        o_overflow;

   weight_tile_router dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_reg_clear      (i_reg_clear),
      .i_addr_write_en  (i_addr_write_en),
      .i_id             (i_id),
      .i_start_addr     (i_start_addr),
      .i_end_addr       (i_end_addr),
      .i_route_en       (i_route_en),
      .i_read_start     (i_read_start),
      .i_read_end       (i_read_end),
      .o_sram_re        (o_sram_re),
      .o_sram_addr      (o_sram_addr),
      .i_sram_data      (i_sram_data),
      .i_pop_en         (i_pop_en),
      .o_data           (o_data),
      .o_valid          (o_valid),
      .o_fifo_pop_ready (o_fifo_pop_ready),
      .o_fifo_empty     (o_fifo_empty),
      .o_overflow       (o_overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] sram [256];

   always @(posedge clk)
      if (o_sram_re) i_sram_data <= sram[o_sram_addr];

   int tests = 0;
   int fails = 0;

   logic [7:0] ss [4];
   logic [7:0] se [4];
   logic [7:0] q [4][$];
   logic [7:0] last_d [4];
   bit         ovf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lanes();
      return {last_d[3], last_d[2], last_d[1], last_d[0]};
   endfunction

   function automatic bit any_q();
      for (int k = 0; k < 4; k++)
         if (q[k].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         ss[k] = '0;
         se[k] = '0;
         q[k].delete();
         last_d[k] = '0;
      end
      ovf = 1'b0;
   endtask

   task automatic wslot(input int id, input int s, input int e);
      i_addr_write_en = 1'b1;
      i_id = 2'(id);
      i_start_addr = 8'(s);
      i_end_addr = 8'(e);
      tick();
      i_addr_write_en = 1'b0;
      ss[id] = 8'(s);
      se[id] = 8'(e);
   endtask

   task automatic do_clear();
      i_reg_clear = 1'b1;
      tick();
      i_reg_clear = 1'b0;
      model_reset();
   endtask

   // every address in [rs,re) is broadcast to each slot range that holds it
   task automatic model_fill(input int rs, input int re);
      for (int a = rs; a < re; a++)
         for (int k = 0; k < 4; k++)
            if (a >= int'(ss[k]) && a < int'(se[k])) begin
               if (q[k].size() < 16) q[k].push_back(sram[a]);
               else ovf = 1'b1;
            end
   endtask

   task automatic run_scan(input int rs, input int re);
      int  last, pr, nreads, ea;
      bit  aok;
      model_fill(rs, re);
      i_read_start = 8'(rs);
      i_read_end = 8'(re);
      i_route_en = 1'b1;
      tick();
      i_route_en = 1'b0;
      last = -1; pr = -1; nreads = 0; ea = rs; aok = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (o_sram_re) begin
            if (int'(o_sram_addr) != ea) aok = 1'b0;
            ea++;
            nreads++;
            last = c;
         end
         if (o_fifo_pop_ready) begin
            pr = c;
            break;
         end
         tick();
      end
      chk("scan_ready_seen", pr >= 0, 1);
      chk("scan_reads", nreads, (re > rs) ? re - rs : 0);
      chk("scan_addr_seq", aok, 1);
      if (nreads > 0) chk("ready_latency", pr - last, 2);
      else            chk("ready_latency_empty", pr, 1);
      chk("scan_overflow", o_overflow, ovf);
      chk("scan_empty", o_fifo_empty, !any_q());
      chk("scan_re_idle", o_sram_re, 0);
   endtask

   task automatic pop_step(output bit more);
      logic [3:0] ev;
      i_pop_en = 1'b1;
      tick();
      i_pop_en = 1'b0;
      ev = '0;
      for (int k = 0; k < 4; k++)
         if (q[k].size() > 0) begin
            ev[k] = 1'b1;
            last_d[k] = q[k].pop_front();
         end
      more = any_q();
      chk("pop_valid", o_valid, ev);
      chk("pop_data", o_data, lanes());
      chk("pop_ready", o_fifo_pop_ready, more);
      chk("pop_empty", o_fifo_empty, !more);
   endtask

   task automatic idle_step();
      i_pop_en = 1'b0;
      tick();
      chk("gap_valid", o_valid, 0);
      chk("gap_data_hold", o_data, lanes());
   endtask

   task automatic drain(input bit gaps);
      bit more;
      for (int i = 0; i < 40; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle_step();
         pop_step(more);
         if (!more) break;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      for (int a = 0; a < 256; a++) sram[a] = 8'(a);
      model_reset();
      tick();
      tick();
      i_rst = 1'b0;
      tick();
      chk("rst_sram_re", o_sram_re, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_pop_ready", o_fifo_pop_ready, 0);
      chk("rst_empty", o_fifo_empty, 1);
      chk("rst_overflow", o_overflow, 0);

      // four disjoint ranges, one word per lane per pop
      wslot(0, 0, 4);
      wslot(1, 4, 8);
      wslot(2, 8, 12);
      wslot(3, 12, 16);
      run_scan(0, 16);
      drain(1'b0);

      // overlapping ranges broadcast, empty slots match nothing
      wslot(0, 0, 8);
      wslot(1, 4, 8);
      wslot(2, 0, 0);
      wslot(3, 0, 0);
      run_scan(0, 8);
      drain(1'b0);

      // overflow on lane 0 keeps the first 16 words
      wslot(0, 0, 20);
      wslot(1, 0, 0);
      run_scan(0, 20);
      drain(1'b0);
      chk("ovf_sticky", o_overflow, 1);
      do_clear();
      chk("ovf_cleared", o_overflow, 0);

      // zero-length scan
      wslot(0, 0, 8);
      run_scan(5, 5);
      drain(1'b0);

      // clear in the middle of a scan
      wslot(0, 0, 4);
      wslot(1, 4, 8);
      wslot(2, 8, 12);
      wslot(3, 12, 16);
      i_read_start = 8'd0;
      i_read_end = 8'd16;
      i_route_en = 1'b1;
      tick();
      i_route_en = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (o_sram_re && o_sram_addr == 8'd3) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("clr_reach_addr3", found, 1);
      i_reg_clear = 1'b1;
      tick();
      i_reg_clear = 1'b0;
      model_reset();
      chk("clr_sram_re", o_sram_re, 0);
      chk("clr_empty", o_fifo_empty, 1);
      chk("clr_pop_ready", o_fifo_pop_ready, 0);
      chk("clr_data", o_data, 0);
      tick();
      chk("clr_empty_settled", o_fifo_empty, 1);
      run_scan(0, 8);
      drain(1'b0);

      // randomized ranges, contents and pop gaps
      for (int it = 0; it < 10; it++) begin
         int rs, re;
         for (int a = 0; a < 256; a++) sram[a] = 8'($urandom);
         for (int k = 0; k < 4; k++)
            wslot(k, $urandom_range(0, 47), $urandom_range(0, 63));
         rs = $urandom_range(0, 40);
         re = rs + $urandom_range(0, 30);
         if ($urandom_range(0, 7) == 0) re = rs;
         run_scan(rs, re);
         drain(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
